// File: rtl/gen_sp_ram.sv
// gen_sp_ram: single-port synchronous RAM with configurable read pipeline, write-port read mode and built-in clear sequencer
module gen_sp_ram #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 8,
  parameter int READ_MODE = 0,
  parameter int WRITE_MODE = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic              busy,
  output logic [DATA_W-1:0] dout
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {RUN, CLEAR} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] cnt, wa;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] s1, s2, rd_data, wd;
  logic clearing, we;
  assign clearing = state == CLEAR;
  assign busy = clearing;
  assign we = !reset && (clearing || (ce && wre));
  assign wa = clearing ? cnt : ad;
  assign wd = clearing ? CLEAR_VAL : din;
  assign rd_data = mem[ad];
  assign dout = READ_MODE == 1 ? s2 : s1;
  always_comb begin
    state_d = clearing ? (cnt == '1 ? RUN : CLEAR) : (clr ? CLEAR : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      cnt <= '0;
    end else begin
      state <= state_d;
      if (clearing) cnt <= cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  // stage-1 samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (reset) s1 <= '0;
    else if (!clearing && ce)
      s1 <= !wre ? rd_data : WRITE_MODE == 1 ? din : WRITE_MODE == 2 ? rd_data : s1;
  end
  always_ff @(posedge clk) begin
    if (reset) s2 <= '0;
    else if (oce) s2 <= s1;
  end
endmodule

// File: tb/tb_gen_sp_ram.sv
// tb_gen_sp_ram: directed bench for gen_sp_ram over five configurations, with a behavioural array model checked every cycle
module tb_gen_sp_ram;
  logic clk = 0, reset = 1, ce = 0, oce = 1, wre = 0, clr = 0;
  logic [7:0] ad = 0;
  logic [15:0] din = 0;
  logic [5:0] d0, d1, d2, d3;
  logic [15:0] d4;
  logic [4:0] bz;
  logic [15:0] dout_a [5];
  int vectors = 0, miscompares = 0;
  bit started = 0;
  localparam int DW [5] = '{6, 6, 6, 6, 16};
  localparam int AW [5] = '{8, 8, 8, 8, 4};
  localparam int WM [5] = '{0, 1, 2, 0, 0};
  localparam int RM [5] = '{0, 0, 0, 1, 0};
  localparam logic [15:0] CV [5] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hBEEF};

  always #5 clk = ~clk;

  gen_sp_ram u0 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[5:0]), .clr(clr), .busy(bz[0]), .dout(d0));
  gen_sp_ram #(.WRITE_MODE(1)) u1 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[5:0]), .clr(clr), .busy(bz[1]), .dout(d1));
  gen_sp_ram #(.WRITE_MODE(2)) u2 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[5:0]), .clr(clr), .busy(bz[2]), .dout(d2));
  gen_sp_ram #(.READ_MODE(1)) u3 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[5:0]), .clr(clr), .busy(bz[3]), .dout(d3));
  gen_sp_ram #(.DATA_W(16), .ADDR_W(4), .CLEAR_VAL(16'hBEEF)) u4 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad[3:0]), .din(din), .clr(clr), .busy(bz[4]), .dout(d4));

  assign dout_a[0] = {10'b0, d0};
  assign dout_a[1] = {10'b0, d1};
  assign dout_a[2] = {10'b0, d2};
  assign dout_a[3] = {10'b0, d3};
  assign dout_a[4] = d4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-instance word array, clear progress and the two output stages
  logic [15:0] mm [5][256];
  logic [15:0] e1 [5], e2 [5];
  bit mclr [5];
  int midx [5];

  task automatic model_step(input int k);
    int depth = 1 << AW[k];
    int a = int'(ad) % depth;
    logic [15:0] mask = 16'((32'd1 << DW[k]) - 1);
    logic [15:0] d = din & mask;
    logic [15:0] old;
    if (reset) begin
      e1[k] = 0; e2[k] = 0; mclr[k] = 1; midx[k] = 0;
    end else begin
      if (oce) e2[k] = e1[k];
      if (mclr[k]) begin
        mm[k][midx[k]] = CV[k];
        if (midx[k] == depth - 1) mclr[k] = 0;
        midx[k] = (midx[k] + 1) % depth;
      end else begin
        if (ce) begin
          old = mm[k][a];
          if (wre) begin
            mm[k][a] = d;
            if (WM[k] == 1) e1[k] = d;
            else if (WM[k] == 2) e1[k] = old;
          end else e1[k] = old;
        end
        if (clr) begin mclr[k] = 1; midx[k] = 0; end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) model_step(k);
    if (reset) started = 1;
  end

  always @(negedge clk) begin
    if (started)
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(mclr[k]));
        chk($sformatf("dout%0d", k), 32'(dout_a[k]), 32'(RM[k] == 1 ? e2[k] : e1[k]));
      end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    ce = 1; wre = 1; ad = a; din = d;
    step();
    ce = 0; wre = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    ce = 1; wre = 0; ad = a;
    step();
    ce = 0;
  endtask

  task automatic wait_idle(input int k, input int limit, output int n);
    n = 0;
    while (bz[k] && n < limit) begin step(); n++; end
  endtask

  initial begin
    int n;
    step(); step();
    chk("reset_dout", 32'(d0), 0);
    chk("reset_busy", 32'(bz[0]), 1);
    reset = 0;
    // T1: power-up clear length and contents
    wait_idle(0, 400, n);
    chk("t1_busy_len", n, 256);
    for (int a = 0; a < 256; a++) begin
      rd(8'(a));
      if (a % 32 == 0) chk("t1_clear_zero", 32'(d0), 0);
    end
    // T2: write then read back, plus untouched top word
    wr(8'h10, 16'h2A);
    rd(8'h10);
    chk("t2_readback", 32'(d0), 32'h2A);
    rd(8'hFF);
    chk("t2_top_zero", 32'(d0), 0);
    // T3: read port behaviour on a write
    wr(8'h05, 16'h11);
    rd(8'h05);
    chk("t3_pre", 32'(d0), 32'h11);
    wr(8'h05, 16'h3C);
    chk("t3_wm0_hold", 32'(d0), 32'h11);
    chk("t3_wm1_thru", 32'(d1), 32'h3C);
    chk("t3_wm2_old", 32'(d2), 32'h11);
    rd(8'h05);
    chk("t3_wm0_new", 32'(d0), 32'h3C);
    chk("t3_wm1_new", 32'(d1), 32'h3C);
    chk("t3_wm2_new", 32'(d2), 32'h3C);
    // T4: pipelined output and oce gating
    rd(8'h10);
    chk("t4_lat1", 32'(d3), 32'h3C);
    step();
    chk("t4_lat2", 32'(d3), 32'h2A);
    oce = 0;
    rd(8'h05);
    step(); step();
    chk("t4_oce_hold", 32'(d3), 32'h2A);
    oce = 1;
    step();
    chk("t4_oce_resume", 32'(d3), 32'h3C);
    // T5: requested clear of the 16-word instance, write while busy dropped
    clr = 1;
    step();
    clr = 0;
    n = 0;
    while (bz[4] && n < 100) begin
      if (n == 14) begin ce = 1; wre = 1; ad = 8'h02; din = 16'h1234; end
      else begin ce = 0; wre = 0; end
      step();
      n++;
    end
    ce = 0; wre = 0;
    chk("t5_busy_len", n, 16);
    for (int a = 0; a < 16; a++) begin
      rd(8'(a));
      chk("t5_beef", 32'(d4), 32'hBEEF);
    end
    wait_idle(0, 400, n);
    chk("t5_big_idle", 32'(bz[0]), 0);
    // T6: reset mid-clear restarts from word 0
    wr(8'hC8, 16'h15);
    wr(8'h05, 16'h2A);
    rd(8'hC8);
    chk("t6_pre", 32'(d0), 32'h15);
    clr = 1;
    step();
    clr = 0;
    repeat (100) step();
    reset = 1;
    step();
    chk("t6_busy_in_reset", 32'(bz[0]), 1);
    chk("t6_dout_reset", 32'(d0), 0);
    reset = 0;
    wait_idle(0, 400, n);
    chk("t6_busy_len", n, 256);
    for (int a = 0; a < 256; a++) begin
      rd(8'(a));
      if (a == 5 || a == 200) chk("t6_cleared", 32'(d0), 0);
    end
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
